alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The module SHALL have port start  input  1  request; sampled at a rising edge when busy=0.
REQ-005 The module SHALL have port opcode  input  4  operation select, latched on accepted start.
REQ-006 The module SHALL have ports a, b  input  WIDTH  operands, latched on accepted start.
REQ-007 The module SHALL have port busy  output  1  high while a multi-cycle operation runs.
REQ-008 The module SHALL have port done  output  1  one-cycle pulse when x, y, zero, err are valid.
REQ-009 The module SHALL have ports x, y  output  WIDTH  primary and secondary results.
REQ-010 The module SHALL have ports zero, err  output  1  x==0 flag; illegal-op or divide-by-zero flag.

Function
REQ-011 Opcodes SHALL be: 0 ADD (x=a+b, y=carry in bit 0); 1 SUB (x=a-b, y=borrow in bit 0); 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 SHL (a by b[clog2(WIDTH)-1:0]); 7 SHR logical, same amount; 8 MUL (x=low, y=high half of product); 9 DIV unsigned (x=quotient, y=remainder).
REQ-012 For opcodes 2..7, y SHALL be 0.
REQ-013 Opcodes 10..15 SHALL be illegal: x=0, y=0, err=1, latency 1.
REQ-014 FSM states SHALL be IDLE, RUN, FIN.
REQ-015 In IDLE, start=1 SHALL latch a, b, opcode. Opcodes 0..7 and 10..15 SHALL go to FIN. Opcodes 8/9 SHALL go to RUN with busy=1.
REQ-016 RUN SHALL perform one shift-add (MUL) or restoring-subtract (DIV) step per cycle, WIDTH steps, then go to FIN.
REQ-017 FIN SHALL drive done=1 for exactly one cycle, then return to IDLE; busy=0 in FIN.
REQ-018 Latency from the accepting edge to the edge that raises done SHALL be 1 cycle for single-cycle ops and WIDTH+1 for MUL/DIV.
REQ-019 start while busy=1 SHALL be ignored; operands and opcode SHALL not change mid-operation.
REQ-020 start asserted during the FIN cycle SHALL be accepted (back-to-back); results update at the next completion.
REQ-021 x, y, zero, err SHALL hold their last values until the next done.
REQ-022 zero SHALL equal (x==0) for every completion, including err cases.
REQ-023 DIV with b=0 SHALL give x=all ones, y=a, err=1, with the normal WIDTH+1 latency.
REQ-024 All arithmetic SHALL be unsigned modulo 2^WIDTH; MUL SHALL be exact in 2*WIDTH bits.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE and busy=0, done=0, x=0, y=0, zero=0, err=0, independent of clk.
REQ-026 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst release SHALL be accepted normally.

Configuration
REQ-027 Macro ALU_MC_DIV_EN defined SHALL compile in the divider, giving opcode 9 as REQ-011/REQ-023.
REQ-028 Without ALU_MC_DIV_EN, opcode 9 SHALL be treated as illegal per REQ-013, with latency 1 and no divider logic.

Verification (WIDTH=8)
REQ-029 ADD a=0xFF, b=0x01 -> done 1 cycle later; x=0x00, y=0x01, zero=1, err=0.
REQ-030 MUL a=200, b=3 -> busy for 8 cycles; done at cycle 9; x=0x58, y=0x02.
REQ-031 DIV a=200, b=7 (ALU_MC_DIV_EN) -> x=0x1C, y=0x04, at cycle 9. DIV b=0 -> x=0xFF, y=200, err=1. Without the macro, DIV -> x=0, y=0, err=1 at cycle 1.
REQ-032 Start MUL, assert start with new operands at cycle 3 -> ignored; result matches first operands.
REQ-033 rst at cycle 4 of MUL -> all outputs 0 at once, no done. Then SHL a=0x81, b=0x09 (amount 1) -> x=0x02, y=0.
REQ-034 Opcode 12 -> x=0, y=0, zero=1, err=1 after 1 cycle. Back-to-back start in the FIN cycle -> accepted.

Source files
------------

// File: rtl/alu_mc_if.sv
// Request/result bundle for alu_mc: operands and opcode in, busy/done and results out.
// The master drives start/opcode/a/b; the ALU (slave) drives busy/done/x/y/zero/err.
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             err;

    modport master (
        output start, opcode, a, b,
        input  busy, done, x, y, zero, err
    );

    modport slave (
        input  start, opcode, a, b,
        output busy, done, x, y, zero, err
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU, shift-add MUL and optional restoring DIV (macro ALU_MC_DIV_EN).
// Latency: done 1 cycle after accept for single-cycle ops, WIDTH+1 cycles for MUL/DIV.
// Backpressure: none; start is ignored while busy and accepted in IDLE or FIN.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    localparam int             SW     = $clog2(WIDTH);
    localparam logic [SW-1:0]  LAST   = SW'(WIDTH - 1);
    localparam logic [3:0]     OP_ADD = 4'd0;
    localparam logic [3:0]     OP_SUB = 4'd1;
    localparam logic [3:0]     OP_AND = 4'd2;
    localparam logic [3:0]     OP_OR  = 4'd3;
    localparam logic [3:0]     OP_XOR = 4'd4;
    localparam logic [3:0]     OP_NOT = 4'd5;
    localparam logic [3:0]     OP_SHL = 4'd6;
    localparam logic [3:0]     OP_SHR = 4'd7;
    localparam logic [3:0]     OP_MUL = 4'd8;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0]     OP_DIV = 4'd9;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             busy_c;
    logic             done_c;
    logic             accept;
    logic             is_multi;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [SW-1:0]    cnt;
    logic [WIDTH:0]   mac_w;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] sc_x;
    logic [WIDTH-1:0] sc_y;
    logic             sc_err;

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             err_q;

`ifdef ALU_MC_DIV_EN
    logic [WIDTH-1:0] b_q;
    logic             dz_q;
    logic             div_q;
    logic [WIDTH:0]   rem_w;
    logic [WIDTH-1:0] dif_w;
`endif

    always_comb begin
        is_multi = (bus.opcode == OP_MUL);
`ifdef ALU_MC_DIV_EN
        if (bus.opcode == OP_DIV) begin
            is_multi = 1'b1;
        end
`endif
    end

    // FIN behaves like IDLE for a new request, which gives back-to-back issue.
    assign accept = bus.start && (state != RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = IDLE;
            end
            RUN: begin
                busy_c = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (accept) begin
            state_nxt = is_multi ? RUN : FIN;
        end
    end

    always_comb begin
        sc_x   = '0;
        sc_y   = '0;
        sc_err = 1'b0;
        add_w  = {1'b0, bus.a} + {1'b0, bus.b};
        sub_w  = {1'b0, bus.a} - {1'b0, bus.b};
        case (bus.opcode)
            OP_ADD: begin
                sc_x = add_w[WIDTH-1:0];
                sc_y = WIDTH'(add_w[WIDTH]);
            end
            OP_SUB: begin
                sc_x = sub_w[WIDTH-1:0];
                sc_y = WIDTH'(sub_w[WIDTH]);
            end
            OP_AND: sc_x = bus.a & bus.b;
            OP_OR:  sc_x = bus.a | bus.b;
            OP_XOR: sc_x = bus.a ^ bus.b;
            OP_NOT: sc_x = ~bus.a;
            OP_SHL: sc_x = bus.a << bus.b[SW-1:0];
            OP_SHR: sc_x = bus.a >> bus.b[SW-1:0];
            OP_MUL: begin
            end
`ifdef ALU_MC_DIV_EN
            OP_DIV: begin
            end
`endif
            default: sc_err = 1'b1;
        endcase
    end

    // One iteration per RUN cycle; {acc_hi, acc_lo} ends as {high, low} or {rem, quo}.
    always_comb begin
        mac_w              = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
        {step_hi, step_lo} = {mac_w, acc_lo[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        rem_w = {acc_hi, acc_lo[WIDTH-1]};
        dif_w = rem_w[WIDTH-1:0] - b_q;
        if (div_q) begin
            if (rem_w >= {1'b0, b_q}) begin
                step_hi = dif_w;
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_w[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef ALU_MC_DIV_EN
            b_q    <= '0;
            dz_q   <= 1'b0;
            div_q  <= 1'b0;
`endif
        end else if (accept) begin
            a_q    <= bus.a;
            acc_hi <= '0;
            acc_lo <= bus.b;
            cnt    <= '0;
`ifdef ALU_MC_DIV_EN
            b_q   <= bus.b;
            dz_q  <= (bus.b == '0);
            div_q <= (bus.opcode == OP_DIV);
            if (bus.opcode == OP_DIV) begin
                acc_lo <= bus.a;
            end
`endif
            if (!is_multi) begin
                x_q    <= sc_x;
                y_q    <= sc_y;
                zero_q <= (sc_x == '0);
                err_q  <= sc_err;
            end
        end else if (state == RUN) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                x_q    <= step_lo;
                y_q    <= step_hi;
                zero_q <= (step_lo == '0);
`ifdef ALU_MC_DIV_EN
                err_q  <= div_q && dz_q;
`else
                err_q  <= 1'b0;
`endif
            end
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.x    = x_q;
    assign bus.y    = y_q;
    assign bus.zero = zero_q;
    assign bus.err  = err_q;
endmodule
